// File: rtl/count_uart_pkg.sv
// Purpose: shared types, constants and byte encoding for the count UART transmitter.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package count_uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  // Start bit + 8 data bits + stop bit.
  localparam int FRAME_BITS = 10;

  // 0-9 -> '0'-'9', A-F -> 'A'-'F'.
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Purpose: bit-period timer; bit_done marks the last cycle of each bit period.
// Latency: first bit_done on the CLKS_PER_BIT-th cycle after run rises.
// Backpressure: none; free-runs whenever run is high.
// Ports: clk, reset (async, active-high), run (timer enable), bit_done (pulse).
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic bit_done
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // Counter is parked at zero while idle, so every rise of run starts a fresh period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!run || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign bit_done = run && (cnt == LAST);

endmodule

// File: rtl/count_uart_tx.sv
// Purpose: sends every change of the 4-bit count bus as one 8N1 UART frame.
// Latency: count change sampled one edge later, start bit driven the edge after that.
// Backpressure: one pending slot; a newer value overwrites an unsent one and sets overrun.
// Ports: clk, reset (async, active-high), count[3:0], clear_overrun (in);
//        tx (serial line, idles high), busy (frame in flight), overrun (sticky) (out).
module count_uart_tx
  import count_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter bit ASCII_HEX    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] count,
  input  logic       clear_overrun,
  output logic       tx,
  output logic       busy,
  output logic       overrun
);

  uart_state_t state;
  logic [7:0]  shreg;
  logic [2:0]  idx;
  logic [3:0]  prev;
  logic [3:0]  pend;
  logic        pend_vld;
  logic        bit_done;
  logic        consume;
  logic        change;
  logic [7:0]  pend_byte;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .run      (state != IDLE),
    .bit_done (bit_done)
  );

  assign consume   = (state == IDLE) && pend_vld;
  assign change    = (count != prev);
  assign pend_byte = ASCII_HEX ? nibble_to_ascii(pend) : {4'h0, pend};

  // Pending slot and change detection. A change on the same edge the FSM takes
  // the slot simply refills it; only an unconsumed overwrite counts as overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev     <= 4'h0;
      pend     <= 4'h0;
      pend_vld <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (change) begin
        prev     <= count;
        pend     <= count;
        pend_vld <= 1'b1;
      end else if (consume) begin
        pend_vld <= 1'b0;
      end
      // Set has priority over clear.
      if (change && pend_vld && !consume) begin
        overrun <= 1'b1;
      end else if (clear_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

  // Frame FSM; tx is registered and always reflects the bit currently on the line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      shreg <= 8'h00;
      idx   <= 3'd0;
      tx    <= 1'b1;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pend_vld) begin
            state <= START;
            shreg <= pend_byte;
            tx    <= 1'b0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (bit_done) begin
            state <= DATA;
            idx   <= 3'd0;
            tx    <= shreg[0];
          end
        end
        DATA: begin
          if (bit_done) begin
            if (idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              idx   <= idx + 3'd1;
              shreg <= shreg >> 1;
              tx    <= shreg[1];
            end
          end
        end
        STOP: begin
          if (bit_done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/count_uart_tx.md
# count_uart_tx

Downstream consumer of the 4-bit binary counter: watches the counter's `count` bus and transmits each new value as one 8N1 UART frame on a single serial line. Holds at most one pending value beyond the frame in flight; intermediate values are dropped and flagged. Used to observe the counter on a bench or board without a logic analyser.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit; legal range ≥ 2.
- `ASCII_HEX`, default 1:
  - 1 sends the ASCII hex digit: 0–9 → 0x30–0x39, A–F → 0x41–0x46.
  - 0 sends the raw byte {4'h0, count}.
- `clk` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `count` in 4: counter value, synchronous to `clk`.
- `clear_overrun` in 1: synchronous, single-cycle clear of `overrun`.
- `tx` out 1: serial line; idles high.
- `busy` out 1: high while a frame is on the line.
- `overrun` out 1: sticky; set when an unsent value is overwritten.

## Operation
- Reset values:
  - `tx`=1, `busy`=0, `overrun`=0.
  - FSM=IDLE; pending slot empty; previous-count register `prev`=4'h0.
- Change detect: on each edge where `count` != `prev`:
  - `prev` <= `count`; pending slot <= `count`; pending valid <= 1.
  - A `count` held at 0 after reset sends nothing.
- FSM states and transitions:
  - IDLE: if pending valid, go to START. On that edge: load shift register with the encoded pending value, clear pending valid, drive `tx`=0, set `busy`=1.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits LSB first, CLKS_PER_BIT cycles each, then STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles, then IDLE with `busy`=0.
- Simultaneous load and consume (IDLE takes the slot on the same edge a new change arrives): FSM takes the old value; the new value occupies the slot. No overrun.
- Overrun: a change arrives while pending valid is set and the slot is not consumed that edge.
  - The slot is overwritten with the newest value; `overrun` <= 1.
- `overrun` clears on `clear_overrun`=1. If set and clear coincide, set wins.
- Counter wrap (15 → 0) is an ordinary change and is sent as '0'.
- Reset mid-frame: `tx` returns to 1 asynchronously; the frame is abandoned, not completed.

## Timing
- Latency from `count` change to start bit:
  - `count` changes after counter edge C; this block samples it at edge C+1.
  - `tx` falls after edge C+2 (when IDLE).
- Frame length is exactly 10×CLKS_PER_BIT cycles of `busy`=1.
- `busy` falls at the end of STOP.
- Back-to-back frames: at least one IDLE cycle (`tx`=1, `busy`=0) between the end of STOP and the next start bit.
- Sustained rate is at most one value per 10×CLKS_PER_BIT+1 cycles. A free-running counter (one change per cycle) saturates the block; `overrun` sets and only the latest value per frame slot is sent.

## Structure
- Package `count_uart_pkg`:
  - state enum `uart_state_t` {IDLE, START, DATA, STOP}.
  - `FRAME_BITS`=10.
  - function `nibble_to_ascii` (4-bit → 8-bit).
- Sub-module `uart_bit_timer`:
  - Parameter CLKS_PER_BIT; inputs `clk`, `reset`, `run`; output `bit_done`.
  - `bit_done` pulses on the last cycle of each bit period; the counter restarts when `run` rises.
  - Top level holds the FSM, the 3-bit data index, the shift register, the pending slot and change detection.

## Test plan
All scenarios use CLKS_PER_BIT=4 and drive `count` directly.
- Reset, hold `count`=0 for 100 cycles → `tx`=1, `busy`=0, `overrun`=0; no frame.
- ASCII_HEX=1, step `count` 0 → 3, then hold → one frame appears 2 edges after the change.
  - Bits: start 0; data 1,1,0,0,1,1,0,0 (0x33); stop 1.
  - 40 cycles `busy`=1.
- ASCII_HEX=1, count=10 → data bits 1,0,0,0,0,0,1,0 (0x41). With ASCII_HEX=0 the same value sends 0x0A.
- Change to 1, then 2 and 3 during the frame → frames for 1 then 3 only; `overrun`=1 after 3 is loaded.
  - `overrun` stays set until `clear_overrun`; clear and set in the same cycle leaves it 1.
- Step 15 → 0 (wrap) → frame 0x30 sent.
- Assert `reset` mid-DATA → `tx`=1 and `busy`=0 immediately, before the next edge. The next change after release sends a complete, clean frame.
